// File: rtl/apb_initiator_pkg.sv
// ---------------------------------------------------------------------------
// apbInitiator_package
// Shared types for the APB initiator and the APB decode fabric.
//   apbAddrSt     : 32-bit APB address
//   apbDataSt     : 32-bit APB data
//   apbInitStateT : initiator transfer state (IDLE, SETUP, ACCESS, RESP)
// ---------------------------------------------------------------------------
package apbInitiator_package;

    typedef logic [31:0] apbAddrSt;
    typedef logic [31:0] apbDataSt;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apbInitStateT;

endpackage

// File: rtl/apb_if.sv
// ---------------------------------------------------------------------------
// apb_if
// Single-select APB bus bundle.
//   src : requester side (drives paddr/psel/penable/pwrite/pwdata,
//         receives prdata/pready/pslverr)
//   dst : completer/decoder side (mirror of src)
// ---------------------------------------------------------------------------
interface apb_if;
    import apbInitiator_package::*;

    apbAddrSt paddr;
    logic     psel;
    logic     penable;
    logic     pwrite;
    apbDataSt pwdata;
    apbDataSt prdata;
    logic     pready;
    logic     pslverr;

    modport src (
        output paddr, psel, penable, pwrite, pwdata,
        input  prdata, pready, pslverr
    );

    modport dst (
        input  paddr, psel, penable, pwrite, pwdata,
        output prdata, pready, pslverr
    );

endinterface

// File: rtl/apb_initiator.sv
// ---------------------------------------------------------------------------
// apb_initiator
// Converts a valid/ready request into one APB transfer (SETUP then ACCESS)
// and returns the result on a valid/ready response channel. One transfer is
// in flight at a time. A sticky flag reports accesses that stall longer than
// TIMEOUT_CYCLES; the transfer itself is never abandoned.
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   req_valid/ready   : request handshake
//   req_write/addr/wdata : request payload (wdata ignored for reads)
//   rsp_valid/ready   : response handshake
//   rsp_rdata, rsp_err: read data (0 for writes) and captured pslverr
//   timeout_flag      : sticky stall indication
//   timeout_clr       : clears timeout_flag (a simultaneous set wins)
//   apbOut            : APB requester port
// ---------------------------------------------------------------------------
module apb_initiator
    import apbInitiator_package::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     req_valid,
    output logic     req_ready,
    input  logic     req_write,
    input  apbAddrSt req_addr,
    input  apbDataSt req_wdata,
    output logic     rsp_valid,
    input  logic     rsp_ready,
    output apbDataSt rsp_rdata,
    output logic     rsp_err,
    output logic     timeout_flag,
    input  logic     timeout_clr,
    apb_if.src       apbOut
);

    localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    apbInitStateT     state_q, state_d;
    logic             write_q, write_d;
    apbAddrSt         addr_q,  addr_d;
    apbDataSt         wdata_q, wdata_d;
    apbDataSt         rdata_q, rdata_d;
    logic             err_q,   err_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             flag_q,  flag_d;
    logic             timeout_set;

    always_comb begin
        state_d = state_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d = SETUP;
                    write_d = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                end
            end
            SETUP: begin
                state_d = ACCESS;
                cnt_d   = '0;
            end
            ACCESS: begin
                if (apbOut.pready) begin
                    state_d = RESP;
                    rdata_d = write_q ? '0 : apbOut.prdata;
                    err_d   = apbOut.pslverr;
                end else if (cnt_q != CNT_MAX) begin
                    // Holding at CNT_MAX keeps the counter from wrapping back
                    // through CNT_LAST, so a stall sets the flag only once.
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The wait that brings the counter up to TIMEOUT_CYCLES raises the flag.
    assign timeout_set = (state_q == ACCESS) && !apbOut.pready && (cnt_q == CNT_LAST);
    assign flag_d      = timeout_set | (flag_q & ~timeout_clr);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            flag_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            flag_q  <= flag_d;
        end
    end

    // All outputs come from registered state; pready/rsp_ready never reach
    // the APB outputs combinationally.
    assign req_ready      = (state_q == IDLE) && !rst;
    assign rsp_valid      = (state_q == RESP);
    assign rsp_rdata      = rdata_q;
    assign rsp_err        = err_q;
    assign timeout_flag   = flag_q;

    assign apbOut.psel    = (state_q == SETUP) || (state_q == ACCESS);
    assign apbOut.penable = (state_q == ACCESS);
    assign apbOut.pwrite  = write_q;
    assign apbOut.paddr   = addr_q;
    assign apbOut.pwdata  = wdata_q;

endmodule

// File: tb/tb_apb_initiator.sv
// ---------------------------------------------------------------------------
// tb_apb_initiator
// Directed bench for apb_initiator (TIMEOUT_CYCLES = 8). Inputs are driven
// and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_apb_initiator;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        timeout_flag;
    logic        timeout_clr;

    int errors = 0;
    int checks = 0;

    apb_if bus ();

    apb_initiator #(.TIMEOUT_CYCLES(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .timeout_flag (timeout_flag),
        .timeout_clr  (timeout_clr),
        .apbOut       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One complete transfer starting from an IDLE falling edge, rsp_ready = 1.
    // The completer answers in ACCESS cycle waits+1.
    task automatic run_xfer(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                            input int waits, input logic slverr, input logic [31:0] rd,
                            input logic [31:0] exp_rdata, input logic exp_err);
        chk("idle_req_ready", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = wd;
        bus.pready = 1'b0; bus.pslverr = 1'b0; bus.prdata = 32'h0;
        tick;
        chk("setup_psel",    {31'd0, bus.psel},    32'd1);
        chk("setup_penable", {31'd0, bus.penable}, 32'd0);
        chk("setup_paddr",   bus.paddr,            a);
        chk("setup_pwrite",  {31'd0, bus.pwrite},  {31'd0, wr});
        if (wr) chk("setup_pwdata", bus.pwdata, wd);
        req_valid = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        for (int i = 0; i <= waits; i++) begin
            tick;
            chk("access_penable", {31'd0, bus.penable}, 32'd1);
            chk("access_paddr",   bus.paddr,            a);
            if (i == waits) begin
                bus.pready = 1'b1; bus.prdata = rd; bus.pslverr = slverr;
            end
        end
        tick;
        chk("resp_valid",   {31'd0, rsp_valid},   32'd1);
        chk("resp_psel",    {31'd0, bus.psel},    32'd0);
        chk("resp_penable", {31'd0, bus.penable}, 32'd0);
        chk("resp_rdata",   rsp_rdata,            exp_rdata);
        chk("resp_err",     {31'd0, rsp_err},     {31'd0, exp_err});
        bus.pready = 1'b0; bus.pslverr = 1'b0; bus.prdata = 32'h0;
        tick;
        chk("post_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("post_req_ready", {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        rsp_ready = 1'b1; timeout_clr = 1'b0;
        bus.pready = 1'b0; bus.prdata = 32'h0; bus.pslverr = 1'b0;

        // Reset state
        tick;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
        tick; tick;
        chk("rst_psel",      {31'd0, bus.psel},     32'd0);
        chk("rst_penable",   {31'd0, bus.penable},  32'd0);
        chk("rst_pwrite",    {31'd0, bus.pwrite},   32'd0);
        chk("rst_paddr",     bus.paddr,             32'd0);
        chk("rst_pwdata",    bus.pwdata,            32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid},    32'd0);
        chk("rst_rsp_rdata", rsp_rdata,             32'd0);
        chk("rst_rsp_err",   {31'd0, rsp_err},      32'd0);
        chk("rst_flag",      {31'd0, timeout_flag}, 32'd0);
        rst = 1'b0;
        tick;

        // 1: zero-wait write, completer prdata must not leak into rsp_rdata
        run_xfer(1'b1, 32'h0000_0010, 32'hA5A5_0001, 0, 1'b0, 32'hFFFF_FFFF, 32'h0, 1'b0);

        // 2: read with 3 wait cycles
        run_xfer(1'b0, 32'h0100_0004, 32'h0, 3, 1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0);
        chk("t2_flag", {31'd0, timeout_flag}, 32'd0);

        // 3: slave error, then a clean transfer
        run_xfer(1'b0, 32'h0000_0020, 32'h0, 0, 1'b1, 32'h1234_5678, 32'h1234_5678, 1'b1);
        run_xfer(1'b0, 32'h0000_0028, 32'h0, 1, 1'b0, 32'h00C0_FFEE, 32'h00C0_FFEE, 1'b0);

        // 4: response back-pressure with a request held pending
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_0200;
        tick;
        tick;
        bus.pready = 1'b1; bus.prdata = 32'h0000_55AA;
        tick;
        bus.pready = 1'b0; bus.prdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 5; i++) begin
            chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("bp_rsp_rdata", rsp_rdata,          32'h0000_55AA);
            chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
            chk("bp_psel",      {31'd0, bus.psel},  32'd0);
            tick;
        end
        chk("bp_still_valid", {31'd0, rsp_valid}, 32'd1);
        rsp_ready = 1'b1;
        tick;
        chk("bp_idle_ready", {31'd0, req_ready}, 32'd1);
        chk("bp_idle_psel",  {31'd0, bus.psel},  32'd0);
        tick;
        chk("bp_second_setup", {31'd0, bus.psel}, 32'd1);
        req_valid = 1'b0;
        tick;
        bus.pready = 1'b1; bus.prdata = 32'h0000_0777;
        tick;
        chk("bp_second_rdata", rsp_rdata, 32'h0000_0777);
        bus.pready = 1'b0; bus.prdata = 32'h0;
        tick;

        // 5a: 12-cycle stall sets the flag after the 8th wait; transfer completes
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h0000_0300; req_wdata = 32'h0000_0011;
        tick;
        chk("to_setup_flag", {31'd0, timeout_flag}, 32'd0);
        req_valid = 1'b0;
        for (int i = 1; i <= 13; i++) begin
            tick;
            chk("to_penable", {31'd0, bus.penable},  32'd1);
            chk("to_flag",    {31'd0, timeout_flag}, (i >= 9) ? 32'd1 : 32'd0);
            if (i == 13) bus.pready = 1'b1;
        end
        tick;
        chk("to_resp_valid", {31'd0, rsp_valid},    32'd1);
        chk("to_resp_flag",  {31'd0, timeout_flag}, 32'd1);
        bus.pready = 1'b0;
        tick;
        chk("to_sticky", {31'd0, timeout_flag}, 32'd1);
        timeout_clr = 1'b1;
        tick;
        timeout_clr = 1'b0;
        chk("to_cleared", {31'd0, timeout_flag}, 32'd0);

        // 5b: clear coincident with set leaves 1; after a later clear the
        // saturated counter must not raise the flag again over a long stall
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_0304;
        tick;
        req_valid = 1'b0;
        for (int i = 1; i <= 27; i++) begin
            tick;
            chk("tc_flag", {31'd0, timeout_flag}, (i == 9 || i == 10) ? 32'd1 : 32'd0);
            timeout_clr = (i == 8 || i == 10);
            if (i == 27) begin
                bus.pready = 1'b1; bus.prdata = 32'hCAFE_0001;
            end
        end
        tick;
        chk("tc_resp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("tc_resp_rdata", rsp_rdata,          32'hCAFE_0001);
        bus.pready = 1'b0; bus.prdata = 32'h0;
        tick;

        // 6: reset during the second ACCESS cycle discards the transfer
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_0400;
        tick;
        req_valid = 1'b0;
        tick;
        tick;
        chk("mr_access2_penable", {31'd0, bus.penable}, 32'd1);
        rst = 1'b1; bus.pready = 1'b1; bus.prdata = 32'h0000_0BAD;
        tick;
        chk("mr_psel",      {31'd0, bus.psel},    32'd0);
        chk("mr_penable",   {31'd0, bus.penable}, 32'd0);
        chk("mr_rsp_valid", {31'd0, rsp_valid},   32'd0);
        chk("mr_rsp_rdata", rsp_rdata,            32'd0);
        rst = 1'b0; bus.pready = 1'b0; bus.prdata = 32'h0;
        tick;
        chk("mr_idle_ready", {31'd0, req_ready}, 32'd1);
        run_xfer(1'b0, 32'h0000_0408, 32'h0, 1, 1'b0, 32'h600D_F00D, 32'h600D_F00D, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
